// File: rtl/uart_cfg_rx_if.sv
// rtl/uart_cfg_rx_if.sv - signal bundle between a UART configuration receiver and its user
//
// rx_in     : asynchronous serial line into the receiver, idles high
// par_out   : committed parameter words, word k at [k*DATA_W +: DATA_W]
// upd       : one-cycle strobe after a full packet is committed
// frame_err : one-cycle strobe after a bad stop bit
// timeout   : one-cycle strobe after a stalled packet is abandoned
// busy      : receiver is mid-character or holds a partial packet
interface uart_cfg_rx_if #(
    parameter int DATA_W  = 8,
    parameter int PAR_NUM = 6
);
    logic                        rx_in;
    logic [PAR_NUM*DATA_W-1:0]   par_out;
    logic                        upd;
    logic                        frame_err;
    logic                        timeout;
    logic                        busy;

    modport master (
        output rx_in,
        input  par_out,
        input  upd,
        input  frame_err,
        input  timeout,
        input  busy
    );

    modport slave (
        input  rx_in,
        output par_out,
        output upd,
        output frame_err,
        output timeout,
        output busy
    );
endinterface

// File: rtl/uart_cfg_rx.sv
// rtl/uart_cfg_rx.sv - UART receiver that assembles PAR_NUM characters into a committed parameter packet
//
// clk   : system clock, rising edge
// rst_n : synchronous active-low reset
// bus   : uart_cfg_rx_if slave side (rx_in in; par_out, upd, frame_err, timeout, busy out)
//
// Characters are 8N1-style (one start bit, DATA_W data bits MSB first, one stop bit).
// The first character of a packet lands in the top word, the last in word 0.
// Words are staged privately and copied to par_out only when the last one arrives.
module uart_cfg_rx #(
    parameter int                DATA_W       = 8,
    parameter int                PAR_NUM      = 6,
    parameter int                BIT_CLKS     = 16,
    parameter int                TIMEOUT_BITS = 32,
    parameter logic [DATA_W-1:0] RESET_VAL    = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    uart_cfg_rx_if.slave bus
);
    localparam int HALF_CLKS = BIT_CLKS / 2;
    localparam int TO_CLKS   = TIMEOUT_BITS * BIT_CLKS;
    localparam int CNT_W     = $clog2(BIT_CLKS) + 1;
    localparam int BIT_W     = $clog2(DATA_W) + 1;
    localparam int IDX_W     = $clog2(PAR_NUM) + 1;
    localparam int IDLE_W    = $clog2(TO_CLKS) + 1;

    localparam logic [CNT_W-1:0]  CNT_HALF_LAST = CNT_W'(HALF_CLKS - 1);
    localparam logic [CNT_W-1:0]  CNT_BIT_LAST  = CNT_W'(BIT_CLKS - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE       = CNT_W'(1);
    localparam logic [BIT_W-1:0]  BIT_LAST      = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE       = BIT_W'(1);
    localparam logic [IDX_W-1:0]  IDX_LAST      = IDX_W'(PAR_NUM - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE       = IDX_W'(1);
    localparam logic [IDLE_W-1:0] IDLE_LAST     = IDLE_W'(TO_CLKS - 1);
    localparam logic [IDLE_W-1:0] IDLE_ONE      = IDLE_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [BIT_W-1:0]    bits, bits_n;
    logic [IDLE_W-1:0]   idle_cnt, idle_n;

    logic                rx_m, rx_s, rx_d;
    logic                fall;

    logic [IDX_W-1:0]    idx;
    logic [DATA_W-1:0]   chr;
    logic [DATA_W-1:0]   stage [PAR_NUM];
    logic [DATA_W-1:0]   par_q [PAR_NUM];
    logic                upd_q, ferr_q, tout_q;

    logic                ev_shift, ev_stop_ok, ev_ferr, ev_tout;

    // Two flops resolve metastability; rx_d only exists to find the falling edge.
    // All three reset high so a line that is low out of reset looks like a start,
    // while a line that stays high does not.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= bus.rx_in;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    // A stop-bit error leaves rx_s low; no new edge is produced until the line
    // has returned high, which is what keeps a broken frame from re-triggering.
    assign fall = rx_d & ~rx_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bits     <= '0;
            idle_cnt <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bits     <= bits_n;
            idle_cnt <= idle_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        bits_n     = bits;
        idle_n     = idle_cnt;
        ev_shift   = 1'b0;
        ev_stop_ok = 1'b0;
        ev_ferr    = 1'b0;
        ev_tout    = 1'b0;

        case (state)
            S_IDLE: begin
                cnt_n  = '0;
                bits_n = '0;
                // A start edge wins over a timeout landing in the same cycle,
                // so the new character continues the current packet.
                if (fall) begin
                    state_n = S_START;
                    idle_n  = '0;
                end else if (idx != '0) begin
                    if (idle_cnt == IDLE_LAST) begin
                        ev_tout = 1'b1;
                        idle_n  = '0;
                    end else begin
                        idle_n = idle_cnt + IDLE_ONE;
                    end
                end else begin
                    idle_n = '0;
                end
            end

            S_START: begin
                if (cnt == CNT_HALF_LAST) begin
                    cnt_n = '0;
                    // High at the centre of the start bit means it was a glitch.
                    state_n = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end

            S_DATA: begin
                if (cnt == CNT_BIT_LAST) begin
                    cnt_n    = '0;
                    ev_shift = 1'b1;
                    if (bits == BIT_LAST) begin
                        bits_n  = '0;
                        state_n = S_STOP;
                    end else begin
                        bits_n = bits + BIT_ONE;
                    end
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end

            S_STOP: begin
                if (cnt == CNT_BIT_LAST) begin
                    cnt_n   = '0;
                    state_n = S_IDLE;
                    if (rx_s) begin
                        ev_stop_ok = 1'b1;
                    end else begin
                        ev_ferr = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx    <= '0;
            chr    <= '0;
            upd_q  <= 1'b0;
            ferr_q <= 1'b0;
            tout_q <= 1'b0;
            for (int k = 0; k < PAR_NUM; k++) begin
                stage[k] <= RESET_VAL;
                par_q[k] <= RESET_VAL;
            end
        end else begin
            upd_q  <= 1'b0;
            ferr_q <= 1'b0;
            tout_q <= 1'b0;

            if (ev_shift) begin
                chr <= {chr[DATA_W-2:0], rx_s};
            end

            if (ev_stop_ok) begin
                for (int k = 0; k < PAR_NUM; k++) begin
                    if (idx == IDX_W'(PAR_NUM - 1 - k)) begin
                        stage[k] <= chr;
                    end
                end
                if (idx == IDX_LAST) begin
                    // Last character goes to word 0; it bypasses staging so the
                    // whole packet becomes visible on a single edge.
                    for (int k = 0; k < PAR_NUM; k++) begin
                        par_q[k] <= (k == 0) ? chr : stage[k];
                    end
                    idx   <= '0;
                    upd_q <= 1'b1;
                end else begin
                    idx <= idx + IDX_ONE;
                end
            end

            if (ev_ferr) begin
                ferr_q <= 1'b1;
                idx    <= '0;
                for (int k = 0; k < PAR_NUM; k++) begin
                    stage[k] <= RESET_VAL;
                end
            end

            // par_out is deliberately left alone: the last good packet stays valid.
            if (ev_tout) begin
                tout_q <= 1'b1;
                idx    <= '0;
            end
        end
    end

    for (genvar g = 0; g < PAR_NUM; g++) begin : g_par
        assign bus.par_out[g*DATA_W +: DATA_W] = par_q[g];
    end

    assign bus.upd       = upd_q;
    assign bus.frame_err = ferr_q;
    assign bus.timeout   = tout_q;
    assign bus.busy      = (state != S_IDLE) || (idx != '0);
endmodule

// File: tb/tb_uart_cfg_rx.sv
// tb/tb_uart_cfg_rx.sv - self-checking bench for uart_cfg_rx
module tb_uart_cfg_rx;
    localparam int BC  = 16;
    localparam int BCP = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_q;

    always #5 clk = ~clk;

    uart_cfg_rx_if #(.DATA_W(8),  .PAR_NUM(6)) ifa ();
    uart_cfg_rx_if #(.DATA_W(12), .PAR_NUM(3)) ifb ();

    uart_cfg_rx #(
        .DATA_W(8), .PAR_NUM(6), .BIT_CLKS(BC), .TIMEOUT_BITS(32), .RESET_VAL(8'h00)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(ifa.slave)
    );

    uart_cfg_rx #(
        .DATA_W(12), .PAR_NUM(3), .BIT_CLKS(BCP), .TIMEOUT_BITS(32), .RESET_VAL(12'h000)
    ) dut_p (
        .clk(clk),
        .rst_n(rst_n),
        .bus(ifb.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_upd    = 0;
    int n_ferr   = 0;
    int n_tout   = 0;
    int n_upd_p  = 0;
    int cyc      = 0;
    int last_tout_cyc = 0;
    logic [47:0] prev_par;
    logic [35:0] prev_par_p;

    // Reference model: characters of the packet in arrival order.
    logic [7:0]  q [$];
    logic [47:0] exp_par = '0;
    int exp_upd  = 0;
    int exp_ferr = 0;
    int exp_tout = 0;

    typedef struct {
        int          n;
        logic [47:0] b;
        int          bad;
        logic [47:0] exp_par;
        int          d_upd;
        int          d_ferr;
    } vec_t;

    vec_t vt [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_char(input logic [7:0] c, input bit ok);
        if (!ok) begin
            exp_ferr++;
            q.delete();
        end else begin
            q.push_back(c);
            if (q.size() == 6) begin
                for (int k = 0; k < 6; k++) exp_par[k*8 +: 8] = q[5-k];
                exp_upd++;
                q.delete();
            end
        end
    endfunction

    function automatic void model_timeout();
        if (q.size() != 0) begin
            exp_tout++;
            q.delete();
        end
    endfunction

    task automatic model_check(input string tag);
        check({tag, "_upd"},  n_upd,  exp_upd);
        check({tag, "_ferr"}, n_ferr, exp_ferr);
        check({tag, "_tout"}, n_tout, exp_tout);
        check({tag, "_par"},  ifa.par_out, exp_par);
        check({tag, "_busy"}, ifa.busy, (q.size() != 0));
    endtask

    task automatic drive(input int which, input logic v);
        if (which == 0) ifa.rx_in = v;
        else            ifb.rx_in = v;
    endtask

    task automatic send_char(input int which, input logic [11:0] d, input int nb, input int bc,
                             input bit stop_ok, input int gap_bits);
        drive(which, 1'b0);
        repeat (bc) @(negedge clk);
        for (int i = nb - 1; i >= 0; i--) begin
            drive(which, d[i]);
            repeat (bc) @(negedge clk);
        end
        drive(which, stop_ok);
        repeat (bc) @(negedge clk);
        drive(which, 1'b1);
        repeat (gap_bits * bc) @(negedge clk);
    endtask

    task automatic send_model(input logic [7:0] c, input bit ok, input int gap_bits);
        send_char(0, {4'h0, c}, 8, BC, ok, gap_bits);
        model_char(c, ok);
    endtask

    task automatic glitch();
        ifa.rx_in = 1'b0;
        repeat (3) @(negedge clk);
        ifa.rx_in = 1'b1;
        repeat (2 * BC) @(negedge clk);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            rst_q = rst_n;
        end
    end

    // Pulse counters plus the always-on rules: strobes exclusive, par_out moves only with upd.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_q === 1'b1) begin
                if (ifa.upd === 1'b1)       n_upd++;
                if (ifa.frame_err === 1'b1) n_ferr++;
                if (ifa.timeout === 1'b1) begin
                    n_tout++;
                    last_tout_cyc = cyc;
                end
                if (ifb.upd === 1'b1)       n_upd_p++;
                if (ifa.upd || ifa.frame_err || ifa.timeout)
                    check("strobe_excl", 32'(ifa.upd) + 32'(ifa.frame_err) + 32'(ifa.timeout), 1);
                if (ifa.par_out !== prev_par)
                    check("par_change_without_upd", ifa.upd, 1);
                if (ifb.par_out !== prev_par_p)
                    check("par_p_change_without_upd", ifb.upd, 1);
            end
            prev_par   = ifa.par_out;
            prev_par_p = ifb.par_out;
        end
    end

    initial begin
        int base_upd, base_ferr, base_tout, t_end;

        vt[0] = '{6, 48'h284D90C4FF50, -1, 48'h284D90C4FF50, 1, 0};
        vt[1] = '{3, 48'h112233000000,  2, 48'h284D90C4FF50, 0, 1};
        vt[2] = '{6, 48'hA55A00FF0180, -1, 48'hA55A00FF0180, 1, 0};
        vt[3] = '{6, 48'hDEADBEEF1234,  5, 48'hA55A00FF0180, 0, 1};
        vt[4] = '{6, 48'h010203040506, -1, 48'h010203040506, 1, 0};
        vt[5] = '{1, 48'h7E0000000000,  0, 48'h010203040506, 0, 1};
        vt[6] = '{6, 48'h807F0001FEFF, -1, 48'h807F0001FEFF, 1, 0};

        rst_n     = 1'b0;
        ifa.rx_in = 1'b1;
        ifb.rx_in = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_par",   ifa.par_out, 48'h0);
        check("rst_upd",   ifa.upd, 0);
        check("rst_ferr",  ifa.frame_err, 0);
        check("rst_tout",  ifa.timeout, 0);
        check("rst_busy",  ifa.busy, 0);
        check("rst_par_p", ifb.par_out, 36'h0);
        rst_n = 1'b1;
        repeat (2 * BC) @(negedge clk);

        for (int r = 0; r < 7; r++) begin
            base_upd  = n_upd;
            base_ferr = n_ferr;
            base_tout = n_tout;
            for (int i = 0; i < vt[r].n; i++)
                send_model(vt[r].b[47-8*i -: 8], (i != vt[r].bad), 2);
            repeat (2 * BC) @(negedge clk);
            check("vec_upd",  n_upd - base_upd,   vt[r].d_upd);
            check("vec_ferr", n_ferr - base_ferr, vt[r].d_ferr);
            check("vec_tout", n_tout - base_tout, 0);
            check("vec_par",  ifa.par_out, vt[r].exp_par);
            check("vec_busy", ifa.busy, 0);
        end

        // Stalled packet: three characters then the line stays high.
        send_model(8'h11, 1'b1, 2);
        send_model(8'h22, 1'b1, 2);
        send_model(8'h33, 1'b1, 2);
        t_end = cyc - 2 * BC;
        check("tout_busy_mid", ifa.busy, 1);
        repeat (31 * BC) @(negedge clk);
        model_timeout();
        model_check("tout");
        check("tout_pos", ((last_tout_cyc - t_end) >= 31 * BC) && ((last_tout_cyc - t_end) <= 33 * BC), 1);
        send_model(8'h9A, 1'b1, 2);
        send_model(8'hBC, 1'b1, 2);
        send_model(8'hDE, 1'b1, 2);
        send_model(8'hF0, 1'b1, 2);
        send_model(8'h12, 1'b1, 2);
        send_model(8'h34, 1'b1, 2);
        model_check("after_tout");

        // Short low pulses, idle and mid-packet: no error and the packet position is kept.
        glitch();
        model_check("glitch_idle");
        send_model(8'hC3, 1'b1, 2);
        send_model(8'h3C, 1'b1, 2);
        glitch();
        send_model(8'h5A, 1'b1, 2);
        send_model(8'hA5, 1'b1, 2);
        send_model(8'h0F, 1'b1, 2);
        send_model(8'hF0, 1'b1, 2);
        model_check("glitch_mid");

        for (int i = 0; i < 36; i++)
            send_model(8'($urandom_range(0, 255)), ($urandom_range(0, 9) != 0), $urandom_range(1, 4));
        repeat (3 * BC) @(negedge clk);
        model_check("rand");
        repeat (34 * BC) @(negedge clk);
        model_timeout();
        model_check("rand_idle");

        // Reset during the 4th data bit of the second character (0xFF keeps the line high).
        send_model(8'h3C, 1'b1, 2);
        ifa.rx_in = 1'b0;
        repeat (BC) @(negedge clk);
        ifa.rx_in = 1'b1;
        repeat (3 * BC + BC / 2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        exp_par = '0;
        check("mrst_par",   ifa.par_out, 48'h0);
        check("mrst_upd",   ifa.upd, 0);
        check("mrst_ferr",  ifa.frame_err, 0);
        check("mrst_tout",  ifa.timeout, 0);
        check("mrst_busy",  ifa.busy, 0);
        check("mrst_par_p", ifb.par_out, 36'h0);
        repeat (6 * BC) @(negedge clk);
        send_model(8'h10, 1'b1, 2);
        send_model(8'h20, 1'b1, 2);
        send_model(8'h30, 1'b1, 2);
        send_model(8'h40, 1'b1, 2);
        send_model(8'h50, 1'b1, 2);
        send_model(8'h60, 1'b1, 2);
        model_check("after_mrst");

        // 12-bit, 3-word instance.
        send_char(1, 12'hABC, 12, BCP, 1'b1, 2);
        check("p_busy_mid", ifb.busy, 1);
        send_char(1, 12'h001, 12, BCP, 1'b1, 2);
        send_char(1, 12'h800, 12, BCP, 1'b1, 2);
        repeat (2 * BCP) @(negedge clk);
        check("p_upd",  n_upd_p, 1);
        check("p_par",  ifb.par_out, 36'hABC001800);
        check("p_busy", ifb.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
